// File: rtl/cfeb_match_pkg.sv
// Shared definitions for the LCT/L1A match logic: state encoding and default widths.
package cfeb_match_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } match_state_e;

  localparam int unsigned WIN_W_DEF = 4;
  localparam int unsigned CNT_W_DEF = 16;

endpackage

// File: rtl/lct_l1a_match_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         CLK,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count events, holding at all-ones instead of wrapping.
  always_ff @(posedge CLK) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lct_l1a_match.sv
// LCT/L1A coincidence matcher. Classifies each L1A as MATCH/NOMATCH against a
// window opened by the delayed LCT, and flags LCT windows that expire unused.
// Optional saturating event counters are built when LCT_L1A_CNT_EN is defined;
// otherwise the count outputs are tied to zero and CNT_CLR is ignored.
module lct_l1a_match
  import cfeb_match_pkg::*;
#(
  parameter int unsigned WIN_W = WIN_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LCT_DLY,
  input  logic             L1A,
  input  logic [WIN_W-1:0] WIN,
  input  logic             CNT_CLR,
  output logic             L1A_MATCH,
  output logic             L1A_NOMATCH,
  output logic             LCT_TMO,
  output logic             WIN_OPEN,
  output logic [CNT_W-1:0] MATCH_CNT,
  output logic [CNT_W-1:0] NOMATCH_CNT,
  output logic [CNT_W-1:0] TMO_CNT
);

  match_state_e     state;
  logic [WIN_W-1:0] rem;
  logic             win_zero;

  assign win_zero = (WIN == '0);
  assign WIN_OPEN = (state == OPEN);

  // Window FSM with registered single-cycle strobes; WIN is captured only when REM loads.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      rem         <= '0;
      L1A_MATCH   <= 1'b0;
      L1A_NOMATCH <= 1'b0;
      LCT_TMO     <= 1'b0;
    end else begin
      L1A_MATCH   <= 1'b0;
      L1A_NOMATCH <= 1'b0;
      LCT_TMO     <= 1'b0;
      case (state)
        IDLE: begin
          if (L1A) begin
            if (LCT_DLY) L1A_MATCH   <= 1'b1;
            else         L1A_NOMATCH <= 1'b1;
          end else if (LCT_DLY) begin
            if (win_zero) begin
              LCT_TMO <= 1'b1;
            end else begin
              state <= OPEN;
              rem   <= WIN;
            end
          end
        end
        OPEN: begin
          if (L1A) begin
            // A coincident new LCT is absorbed by this same L1A.
            L1A_MATCH <= 1'b1;
            state     <= IDLE;
            rem       <= '0;
          end else if (LCT_DLY) begin
            // Previous LCT times out; the new one restarts the window unless it has zero length.
            LCT_TMO <= 1'b1;
            if (win_zero) begin
              state <= IDLE;
              rem   <= '0;
            end else begin
              rem <= WIN;
            end
          end else if (rem == WIN_W'(1)) begin
            LCT_TMO <= 1'b1;
            state   <= IDLE;
            rem     <= '0;
          end else begin
            rem <= rem - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          rem   <= '0;
        end
      endcase
    end
  end

`ifdef LCT_L1A_CNT_EN
  logic cnt_clr;

  assign cnt_clr = RST | CNT_CLR;

  sat_cnt #(.W(CNT_W)) u_match_cnt (
    .CLK (CLK),
    .clr (cnt_clr),
    .inc (L1A_MATCH),
    .cnt (MATCH_CNT)
  );

  sat_cnt #(.W(CNT_W)) u_nomatch_cnt (
    .CLK (CLK),
    .clr (cnt_clr),
    .inc (L1A_NOMATCH),
    .cnt (NOMATCH_CNT)
  );

  sat_cnt #(.W(CNT_W)) u_tmo_cnt (
    .CLK (CLK),
    .clr (cnt_clr),
    .inc (LCT_TMO),
    .cnt (TMO_CNT)
  );
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = CNT_CLR;
  assign MATCH_CNT      = '0;
  assign NOMATCH_CNT    = '0;
  assign TMO_CNT        = '0;
`endif

endmodule

// File: tb/tb_lct_l1a_match.sv
// Bench for lct_l1a_match: directed vector table, counter saturation/clear
// sequence, then randomized traffic against a deadline-based reference model.
module tb_lct_l1a_match;

  localparam int unsigned WW = 4;
  localparam int unsigned CW = 4;
  localparam int          CMAX = (1 << CW) - 1;
`ifdef LCT_L1A_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          LCT_DLY = 1'b0;
  logic          L1A = 1'b0;
  logic [WW-1:0] WIN = '0;
  logic          CNT_CLR = 1'b0;
  logic          L1A_MATCH, L1A_NOMATCH, LCT_TMO, WIN_OPEN;
  logic [CW-1:0] MATCH_CNT, NOMATCH_CNT, TMO_CNT;

  lct_l1a_match #(.WIN_W(WW), .CNT_W(CW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .LCT_DLY     (LCT_DLY),
    .L1A         (L1A),
    .WIN         (WIN),
    .CNT_CLR     (CNT_CLR),
    .L1A_MATCH   (L1A_MATCH),
    .L1A_NOMATCH (L1A_NOMATCH),
    .LCT_TMO     (LCT_TMO),
    .WIN_OPEN    (WIN_OPEN),
    .MATCH_CNT   (MATCH_CNT),
    .NOMATCH_CNT (NOMATCH_CNT),
    .TMO_CNT     (TMO_CNT)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: an LCT leaves a pending window ending at absolute cycle n+WIN.
  int tcyc = 0;
  bit pend = 1'b0;
  int pend_end = 0;
  bit e_match = 1'b0, e_nomatch = 1'b0, e_tmo = 1'b0, e_open = 1'b0;
  int c_match = 0, c_nomatch = 0, c_tmo = 0;

  typedef struct {
    bit            lct;
    bit            l1a;
    bit            rst;
    bit            clr;
    logic [WW-1:0] win;
    bit            m;
    bit            n;
    bit            t;
    bit            o;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit lct, bit l1a, bit rst, int win, bit m, bit n, bit t, bit o);
    vec_t v;
    v.lct = lct; v.l1a = l1a; v.rst = rst; v.clr = 1'b0; v.win = WW'(win);
    v.m = m; v.n = n; v.t = t; v.o = o;
    tbl.push_back(v);
  endfunction

  function automatic int sat_inc(int c, bit ev);
    return (ev && c < CMAX) ? c + 1 : c;
  endfunction

  function automatic void model(bit lct, bit l1a, bit rst, bit clr, int win);
    if (!CNT_EN || rst || clr) begin
      c_match = 0; c_nomatch = 0; c_tmo = 0;
    end else begin
      c_match   = sat_inc(c_match, e_match);
      c_nomatch = sat_inc(c_nomatch, e_nomatch);
      c_tmo     = sat_inc(c_tmo, e_tmo);
    end
    e_match = 1'b0; e_nomatch = 1'b0; e_tmo = 1'b0;
    if (rst) begin
      pend = 1'b0;
    end else if (l1a) begin
      if (lct || pend) e_match = 1'b1;
      else             e_nomatch = 1'b1;
      pend = 1'b0;
    end else if (lct) begin
      // Either an older window expires or a zero-length window expires at once.
      if (pend || win == 0) e_tmo = 1'b1;
      if (win == 0) begin
        pend = 1'b0;
      end else begin
        pend = 1'b1;
        pend_end = tcyc + win;
      end
    end else if (pend && tcyc == pend_end) begin
      e_tmo = 1'b1;
      pend = 1'b0;
    end
    e_open = pend;
    tcyc++;
  endfunction

  task automatic step(input bit lct, input bit l1a, input bit rst, input bit clr, input int win);
    logic [15:0] got, exp;
    LCT_DLY = lct; L1A = l1a; RST = rst; CNT_CLR = clr; WIN = WW'(win);
    @(posedge CLK); #1;
    model(lct, l1a, rst, clr, win);
    got = {L1A_MATCH, L1A_NOMATCH, LCT_TMO, WIN_OPEN, MATCH_CNT, NOMATCH_CNT, TMO_CNT};
    exp = {e_match, e_nomatch, e_tmo, e_open, CW'(c_match), CW'(c_nomatch), CW'(c_tmo)};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL model cyc=%0d {m,n,t,open,mc,nc,tc} got=%h expected=%h", tcyc, got, exp);
    end
  endtask

  task automatic check_cnt(input string name, input logic [CW-1:0] got, input int exp);
    vectors++;
    if (got !== CW'(exp)) begin
      miscompares++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  initial begin
    // Reset, then the directed scenarios. Each row: inputs for one cycle and the
    // strobes / WIN_OPEN expected one clock later.
    add(0,0,1,0, 0,0,0,0);
    add(0,0,1,0, 0,0,0,0);
    add(0,0,0,0, 0,0,0,0);
    // WIN=3, L1A on the last window cycle
    add(1,0,0,3, 0,0,0,1); add(0,0,0,3, 0,0,0,1); add(0,0,0,3, 0,0,0,1);
    add(0,1,0,3, 1,0,0,0); add(0,0,0,3, 0,0,0,0);
    // WIN=3 expiry, then a late L1A
    add(1,0,0,3, 0,0,0,1); add(0,0,0,3, 0,0,0,1); add(0,0,0,3, 0,0,0,1);
    add(0,0,0,3, 0,0,1,0); add(0,1,0,3, 0,1,0,0); add(0,0,0,3, 0,0,0,0);
    // WIN=0 coincidence and zero-length timeout
    add(1,1,0,0, 1,0,0,0); add(0,0,0,0, 0,0,0,0); add(0,0,0,0, 0,0,0,0);
    add(1,0,0,0, 0,0,1,0); add(0,0,0,0, 0,0,0,0);
    // WIN=2 retrigger
    add(1,0,0,2, 0,0,0,1); add(1,0,0,2, 0,0,1,1); add(0,0,0,2, 0,0,0,1);
    add(0,1,0,2, 1,0,0,0); add(0,0,0,2, 0,0,0,0);
    // WIN=7 window killed by reset
    add(1,0,0,7, 0,0,0,1); add(0,0,0,7, 0,0,0,1); add(0,0,1,7, 0,0,0,0);
    for (int i = 0; i < 8; i++) add(0,0,0,7, 0,0,0,0);
    // Retrigger with WIN=0 closes without a second timeout
    add(1,0,0,2, 0,0,0,1); add(1,0,0,0, 0,0,1,0); add(0,0,0,0, 0,0,0,0);
    // WIN change mid-window is ignored
    add(1,0,0,2, 0,0,0,1); add(0,0,0,9, 0,0,0,1); add(0,0,0,9, 0,0,1,0);
    add(0,0,0,9, 0,0,0,0);
    // L1A with coincident LCT while open, then back-to-back unmatched L1As
    add(1,0,0,2, 0,0,0,1); add(1,1,0,2, 1,0,0,0); add(0,0,0,2, 0,0,0,0);
    add(0,1,0,2, 0,1,0,0); add(0,1,0,2, 0,1,0,0); add(0,0,0,2, 0,0,0,0);
    // WIN=15 boundary: window of sixteen cycles
    add(1,0,0,15, 0,0,0,1);
    for (int i = 0; i < 14; i++) add(0,0,0,15, 0,0,0,1);
    add(0,0,0,15, 0,0,1,0); add(0,0,0,15, 0,0,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      logic [3:0] got, exp;
      step(tbl[i].lct, tbl[i].l1a, tbl[i].rst, tbl[i].clr, int'(tbl[i].win));
      got = {L1A_MATCH, L1A_NOMATCH, LCT_TMO, WIN_OPEN};
      exp = {tbl[i].m, tbl[i].n, tbl[i].t, tbl[i].o};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL table row %0d {m,n,t,open} got=%b expected=%b", i, got, exp);
      end
    end

    // Counter saturation: 20 matches on a 4-bit counter.
    step(0,0,0,1,0);
    for (int i = 0; i < 20; i++) step(1,1,0,0,0);
    step(0,0,0,0,0);
    step(0,0,0,0,0);
    check_cnt("match_cnt_saturated", MATCH_CNT, CNT_EN ? 15 : 0);
    // Clear coincident with a match strobe wins over the increment.
    step(1,1,0,0,0);
    step(0,0,0,1,0);
    check_cnt("match_cnt_clr_vs_inc", MATCH_CNT, 0);
    step(0,0,0,0,0);
    check_cnt("match_cnt_after_clr", MATCH_CNT, 0);
    step(0,1,0,0,0);
    step(0,0,0,0,0);
    step(0,0,0,0,0);
    check_cnt("nomatch_cnt_one", NOMATCH_CNT, CNT_EN ? 1 : 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      bit lct, l1a, rst, clr;
      int win;
      lct = ($urandom_range(0, 3) == 0);
      l1a = ($urandom_range(0, 4) == 0);
      rst = ($urandom_range(0, 199) == 0);
      clr = ($urandom_range(0, 149) == 0);
      win = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4));
      step(lct, l1a, rst, clr, win);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lct_l1a_match.md
# lct_l1a_match

Downstream consumer of the variable-depth LCT delay shift register: takes the pipeline-delayed LCT pulse and the incoming L1A and decides, per L1A, whether it matches an LCT inside a programmable window. Produces single-cycle MATCH / NOMATCH / TIMEOUT strobes for the readout control logic. Optional saturating event counters feed the slow-control status registers.

## Interface
- Parameters:
- `WIN_W`, default 4: width of the window-length input.
- `CNT_W`, default 16: width of each event counter (macro-enabled only).
- Ports:
- `CLK  in  1`: system clock; all logic on the rising edge.
- `RST  in  1`: synchronous, active-high reset.
- `LCT_DLY  in  1`: delayed LCT pulse from the delay shift register output.
- `L1A  in  1`: level-1 accept pulse.
- `WIN  in  WIN_W`: window extension in clocks beyond the LCT cycle.
- `CNT_CLR  in  1`: synchronous clear of all counters.
- `L1A_MATCH  out  1`: L1A fell inside an open window.
- `L1A_NOMATCH  out  1`: L1A with no open window.
- `LCT_TMO  out  1`: LCT window closed with no L1A.
- `WIN_OPEN  out  1`: high while in state OPEN.
- `MATCH_CNT, NOMATCH_CNT, TMO_CNT  out  CNT_W each`: event counters.

## Operation
- States: IDLE and OPEN. A remaining-cycles register `REM` is WIN_W bits wide.
- The window spans the LCT_DLY cycle n through cycle n+WIN inclusive. `window_active = LCT_DLY | (state==OPEN)`.
- IDLE:
  - L1A with LCT_DLY in the same cycle: MATCH; stay in IDLE.
  - L1A alone: NOMATCH.
  - LCT_DLY alone with WIN=0: TMO; stay in IDLE.
  - LCT_DLY alone with WIN>0: go to OPEN, `REM = WIN`.
- OPEN:
  - L1A (with or without LCT_DLY): MATCH, go to IDLE. A simultaneous new LCT is consumed by the same L1A.
  - LCT_DLY without L1A: TMO for the previous LCT, retrigger with `REM = WIN`, stay in OPEN. If WIN=0, go to IDLE instead and issue no extra TMO.
  - No event and `REM==1`: TMO, go to IDLE.
  - No event and `REM>1`: decrement `REM`.
- At most one of MATCH/NOMATCH fires per L1A. TMO may coincide with neither (exclusive by construction).
- WIN is sampled only when `REM` is loaded. Changing it mid-window does not affect the current window.
- Reset mid-window: go to IDLE, `REM = 0`, no TMO issued, pending window discarded.

## Timing
- All strobes are registered and appear exactly 1 clock after the causing input cycle. Each strobe is 1 clock wide.
- WIN_OPEN is registered state: high from cycle n+1 through the last window cycle.
- Reset values: all strobes 0, WIN_OPEN 0, all counters 0.
- Back-to-back L1A on consecutive clocks are each classified independently.

## Configuration
- `LCT_L1A_CNT_EN` defined:
  - Three CNT_W-bit counters increment on their strobe, one clock after the strobe.
  - Counters saturate at all-ones.
  - CNT_CLR and RST clear them. CNT_CLR has priority over an increment in the same cycle.
- `LCT_L1A_CNT_EN` undefined:
  - Counters are not instantiated and the count outputs are tied to 0.
  - CNT_CLR is ignored.
  - Match logic is unchanged.

## Structure
- Shared package/include `cfeb_match_pkg`:
  - State encoding (IDLE=0, OPEN=1).
  - Default WIN_W and CNT_W constants.
- Sub-module `sat_cnt`:
  - Parameterized-width saturating counter with clear and increment.
  - Instantiated three times under the macro.

## Test plan
- WIN=3, LCT_DLY at cycle 10, L1A at cycle 13 -> L1A_MATCH=1 at cycle 14 only. WIN_OPEN high cycles 11–13.
- WIN=3, LCT_DLY at cycle 10, no L1A -> LCT_TMO=1 at cycle 14. An L1A at 14 -> L1A_NOMATCH at 15.
- WIN=0, LCT_DLY and L1A both at cycle 5 -> L1A_MATCH at 6. LCT_DLY alone at 8 -> LCT_TMO at 9.
- WIN=2, LCT_DLY at 10 and 11 -> LCT_TMO at 12 (retrigger). L1A at 13 -> L1A_MATCH at 14.
- WIN=7, LCT_DLY at 10, RST at 12 -> no strobes through cycle 20. WIN_OPEN=0 from 13.
- With `LCT_L1A_CNT_EN` defined, CNT_W=4, 20 matched L1As -> MATCH_CNT saturates at 15. CNT_CLR coincident with a match strobe -> MATCH_CNT=0.
